// File: rtl/configure.sv
// configure: SoC address map shared by the bus arbiter and its slaves.
// Target i is hit when (addr & ~TARGET_MASK[i]) == TARGET_BASE[i].
// Index order matches the arbiter's one-hot bus_valid:
//   0 rom, 1 spi, 2 uart_tx, 3 uart_rx, 4 clint, 5 tim, 6 sram.
package configure;

  localparam int unsigned NUM_TARGETS = 7;

  localparam logic [31:0] ROM_BASE     = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK     = 32'h000F_FFFF;
  localparam logic [31:0] SPI_BASE     = 32'h0010_0000;
  localparam logic [31:0] SPI_MASK     = 32'h000F_FFFF;
  localparam logic [31:0] UART_TX_BASE = 32'h0100_0000;
  localparam logic [31:0] UART_TX_MASK = 32'h0000_00FF;
  localparam logic [31:0] UART_RX_BASE = 32'h0100_0100;
  localparam logic [31:0] UART_RX_MASK = 32'h0000_00FF;
  localparam logic [31:0] CLINT_BASE   = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK   = 32'h0000_FFFF;
  localparam logic [31:0] TIM_BASE     = 32'h1000_0000;
  localparam logic [31:0] TIM_MASK     = 32'h0000_FFFF;
  localparam logic [31:0] SRAM_BASE    = 32'h8000_0000;
  localparam logic [31:0] SRAM_MASK    = 32'h0FFF_FFFF;

  localparam logic [NUM_TARGETS-1:0][31:0] TARGET_BASE = {
    SRAM_BASE, TIM_BASE, CLINT_BASE, UART_RX_BASE, UART_TX_BASE, SPI_BASE, ROM_BASE
  };
  localparam logic [NUM_TARGETS-1:0][31:0] TARGET_MASK = {
    SRAM_MASK, TIM_MASK, CLINT_MASK, UART_RX_MASK, UART_TX_MASK, SPI_MASK, ROM_MASK
  };

endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the single system bus between the instruction-fetch
// port and the data port, one outstanding transaction at a time, and decodes
// the granted address onto one of seven targets from the configure package.
//
// Ports
//   clock, reset          system clock; asynchronous active-low reset
//   imem_valid/addr       fetch request (held until imem_ready)
//   imem_ready/rdata/error  one-cycle fetch completion
//   dmem_valid/addr/wdata/wstrb  data request (wstrb == 0 means read)
//   dmem_ready/rdata/error  one-cycle data completion
//   bus_valid[6:0]        one-hot target select (0 rom .. 6 sram)
//   bus_instr             current transaction is a fetch
//   bus_addr/wdata/wstrb  registered request fields (wstrb 0 for fetches)
//   bus_ready[6:0]        per-target ready
//   bus_rdata[223:0]      per-target read data, target i at [32i+31:32i]
//
// Parameter timeout_cycles: REQ cycles before an error completion (0 = none).
// Build option: define BUS_ARB_RR_EN for round-robin arbitration; otherwise
// the data port has fixed priority over fetch.
module bus_arbiter #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic         reset,
  input  logic         clock,
  input  logic         imem_valid,
  input  logic [31:0]  imem_addr,
  output logic         imem_ready,
  output logic [31:0]  imem_rdata,
  output logic         imem_error,
  input  logic         dmem_valid,
  input  logic [31:0]  dmem_addr,
  input  logic [31:0]  dmem_wdata,
  input  logic [3:0]   dmem_wstrb,
  output logic         dmem_ready,
  output logic [31:0]  dmem_rdata,
  output logic         dmem_error,
  output logic [6:0]   bus_valid,
  output logic         bus_instr,
  output logic [31:0]  bus_addr,
  output logic [31:0]  bus_wdata,
  output logic [3:0]   bus_wstrb,
  input  logic [6:0]   bus_ready,
  input  logic [223:0] bus_rdata
);

  import configure::*;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q;
  logic [6:0]  bus_valid_q;
  logic        bus_instr_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_wstrb_q;
  logic [15:0] tmo_cnt_q;
  logic        imem_ready_q;
  logic        imem_error_q;
  logic [31:0] imem_rdata_q;
  logic        dmem_ready_q;
  logic        dmem_error_q;
  logic [31:0] dmem_rdata_q;
`ifdef BUS_ARB_RR_EN
  logic        last_instr_q;
`endif

  logic        grant_instr_d;
  logic [31:0] grant_addr_d;
  logic [6:0]  hit_raw;
  logic [6:0]  hit_sel_d;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        tmo_hit;
  logic [31:0] rd_chain [NUM_TARGETS+1];

  always_comb begin
    grant_instr_d = 1'b0;
`ifdef BUS_ARB_RR_EN
    if (imem_valid && dmem_valid) begin
      grant_instr_d = ~last_instr_q;
    end else begin
      grant_instr_d = imem_valid;
    end
`else
    grant_instr_d = imem_valid & ~dmem_valid;
`endif
    grant_addr_d = grant_instr_d ? imem_addr : dmem_addr;
  end

  // Per-target hit and read-data select; rdata is an AND-OR over the one-hot
  // select so no index arithmetic is needed on the wide bus.
  assign rd_chain[0] = '0;
  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_target
    assign hit_raw[g] = ((grant_addr_d & ~TARGET_MASK[g]) == TARGET_BASE[g]);
    assign rd_chain[g+1] = rd_chain[g] | (bus_rdata[32*g +: 32] & {32{bus_valid_q[g]}});
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
  assign hit_sel_d = hit_raw & (~hit_raw + 7'd1);
  assign sel_rdata = rd_chain[NUM_TARGETS];
  assign sel_ready = |(bus_ready & bus_valid_q);
  assign tmo_hit   = (timeout_cycles != 0) &&
                     ((32'(tmo_cnt_q) + 32'd1) == 32'(timeout_cycles));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bus_valid_q  <= '0;
      bus_instr_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      tmo_cnt_q    <= '0;
      imem_ready_q <= 1'b0;
      imem_error_q <= 1'b0;
      imem_rdata_q <= '0;
      dmem_ready_q <= 1'b0;
      dmem_error_q <= 1'b0;
      dmem_rdata_q <= '0;
`ifdef BUS_ARB_RR_EN
      last_instr_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (imem_valid || dmem_valid) begin
            bus_instr_q <= grant_instr_d;
            bus_addr_q  <= grant_addr_d;
            bus_wdata_q <= grant_instr_d ? '0 : dmem_wdata;
            bus_wstrb_q <= grant_instr_d ? '0 : dmem_wstrb;
            tmo_cnt_q   <= '0;
`ifdef BUS_ARB_RR_EN
            last_instr_q <= grant_instr_d;
`endif
            if (hit_sel_d != '0) begin
              bus_valid_q <= hit_sel_d;
              state_q     <= REQ;
            end else begin
              // Unmapped: complete with error without touching the bus.
              imem_ready_q <= grant_instr_d;
              imem_error_q <= grant_instr_d;
              dmem_ready_q <= ~grant_instr_d;
              dmem_error_q <= ~grant_instr_d;
              imem_rdata_q <= '0;
              dmem_rdata_q <= '0;
              state_q      <= RESP;
            end
          end
        end
        REQ: begin
          if (sel_ready) begin
            bus_valid_q  <= '0;
            imem_ready_q <= bus_instr_q;
            dmem_ready_q <= ~bus_instr_q;
            if (bus_instr_q) begin
              imem_rdata_q <= sel_rdata;
            end else begin
              dmem_rdata_q <= sel_rdata;
            end
            state_q <= RESP;
          end else if (tmo_hit) begin
            bus_valid_q  <= '0;
            imem_ready_q <= bus_instr_q;
            imem_error_q <= bus_instr_q;
            dmem_ready_q <= ~bus_instr_q;
            dmem_error_q <= ~bus_instr_q;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            state_q      <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        RESP: begin
          imem_ready_q <= 1'b0;
          imem_error_q <= 1'b0;
          imem_rdata_q <= '0;
          dmem_ready_q <= 1'b0;
          dmem_error_q <= 1'b0;
          dmem_rdata_q <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_valid  = bus_valid_q;
  assign bus_instr  = bus_instr_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign imem_ready = imem_ready_q;
  assign imem_error = imem_error_q;
  assign imem_rdata = imem_rdata_q;
  assign dmem_ready = dmem_ready_q;
  assign dmem_error = dmem_error_q;
  assign dmem_rdata = dmem_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a transaction-timeline model predicts every output
// for each round of requests; a negedge process compares all outputs.
module tb_bus_arbiter;

  localparam int unsigned TMO = 8;
  localparam int NSLOT = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         imem_valid = 1'b0;
  logic [31:0]  imem_addr = '0;
  logic         imem_ready;
  logic [31:0]  imem_rdata;
  logic         imem_error;
  logic         dmem_valid = 1'b0;
  logic [31:0]  dmem_addr = '0;
  logic [31:0]  dmem_wdata = '0;
  logic [3:0]   dmem_wstrb = '0;
  logic         dmem_ready;
  logic [31:0]  dmem_rdata;
  logic         dmem_error;
  logic [6:0]   bus_valid;
  logic         bus_instr;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_wstrb;
  logic [6:0]   bus_ready = '0;
  logic [223:0] bus_rdata = '0;

  bus_arbiter #(.timeout_cycles(TMO)) dut (
    .reset(reset), .clock(clock),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .bus_valid(bus_valid), .bus_instr(bus_instr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int off, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at offset %0d: actual=%h required=%h (t=%0t)", name, off, act, req, $time);
    end
  endtask

  // Address map as start/size ranges.
  logic [31:0] t_lo [7] = '{32'h0000_0000, 32'h0010_0000, 32'h0100_0000, 32'h0100_0100,
                            32'h0200_0000, 32'h1000_0000, 32'h8000_0000};
  logic [31:0] t_sz [7] = '{32'h0010_0000, 32'h0010_0000, 32'h0000_0100, 32'h0000_0100,
                            32'h0001_0000, 32'h0001_0000, 32'h1000_0000};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 7; i++)
      if (a >= t_lo[i] && (a - t_lo[i]) < t_sz[i]) return i;
    return -1;
  endfunction

  // Expected and captured per-offset output values for the current round.
  logic [6:0]  e_valid [NSLOT];  logic [6:0]  a_valid [NSLOT];
  logic        e_instr [NSLOT];  logic        a_instr [NSLOT];
  logic [31:0] e_addr  [NSLOT];  logic [31:0] a_addr  [NSLOT];
  logic [31:0] e_wdata [NSLOT];  logic [31:0] a_wdata [NSLOT];
  logic [3:0]  e_wstrb [NSLOT];  logic [3:0]  a_wstrb [NSLOT];
  logic        e_irdy  [NSLOT];  logic        a_irdy  [NSLOT];
  logic        e_ierr  [NSLOT];  logic        a_ierr  [NSLOT];
  logic [31:0] e_irdat [NSLOT];  logic [31:0] a_irdat [NSLOT];
  logic        e_drdy  [NSLOT];  logic        a_drdy  [NSLOT];
  logic        e_derr  [NSLOT];  logic        a_derr  [NSLOT];
  logic [31:0] e_drdat [NSLOT];  logic [31:0] a_drdat [NSLOT];

  // Model state carried between rounds.
  bit          m_last_instr = 1'b1;
  logic        h_instr = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic [3:0]  h_wstrb = '0;

  // Slave behaviour: ready after lat wait cycles, fixed data per port.
  int          s_ilat = 0, s_dlat = 0;
  logic [31:0] s_idata = '0, s_ddata = '0;
  int          scnt = 0;

  bit chk_on = 1'b0;
  int cyc = 0;
  int r_len = 0;

  task automatic model_reset();
    m_last_instr = 1'b1;
    h_instr = 1'b0; h_addr = '0; h_wdata = '0; h_wstrb = '0;
  endtask

  // Timeline model: grant at offset t -> bus active t+1..t+V, completion at
  // t+V+1, next arbitration at t+V+2; unmapped completes at t+1.
  task automatic model_round(input bit ireq, input logic [31:0] iaddr, input int ilat,
                             input logic [31:0] idata, input bit dreq, input logic [31:0] daddr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input int dlat, input logic [31:0] ddata);
    bit pi, pd, win_i, err;
    int t, tg, v, resp, nxt, lat;
    logic [31:0] ad, rd;
    for (int k = 0; k < NSLOT; k++) begin
      e_valid[k] = '0; e_instr[k] = h_instr; e_addr[k] = h_addr;
      e_wdata[k] = h_wdata; e_wstrb[k] = h_wstrb;
      e_irdy[k] = 1'b0; e_ierr[k] = 1'b0; e_irdat[k] = '0;
      e_drdy[k] = 1'b0; e_derr[k] = 1'b0; e_drdat[k] = '0;
    end
    pi = ireq; pd = dreq; t = 0;
    while (pi || pd) begin
      if (pi && pd) begin
`ifdef BUS_ARB_RR_EN
        win_i = !m_last_instr;
`else
        win_i = 1'b0;
`endif
      end else begin
        win_i = pi;
      end
      m_last_instr = win_i;
      ad = win_i ? iaddr : daddr;
      h_instr = win_i; h_addr = ad;
      h_wdata = win_i ? 32'h0 : wdata;
      h_wstrb = win_i ? 4'h0 : wstrb;
      for (int k = t + 1; k < NSLOT; k++) begin
        e_instr[k] = h_instr; e_addr[k] = h_addr; e_wdata[k] = h_wdata; e_wstrb[k] = h_wstrb;
      end
      tg = decode(ad);
      lat = win_i ? ilat : dlat;
      if (tg < 0) begin
        resp = t + 1; err = 1'b1; rd = '0; nxt = t + 2;
      end else begin
        v = (lat + 1 < int'(TMO)) ? lat + 1 : int'(TMO);
        for (int k = 1; k <= v; k++) e_valid[t+k] = 7'(1 << tg);
        resp = t + v + 1;
        err = (lat + 1 > int'(TMO));
        rd = err ? 32'h0 : (win_i ? idata : ddata);
        nxt = t + v + 2;
      end
      if (win_i) begin
        e_irdy[resp] = 1'b1; e_ierr[resp] = err; e_irdat[resp] = rd; pi = 1'b0;
      end else begin
        e_drdy[resp] = 1'b1; e_derr[resp] = err; e_drdat[resp] = rd; pd = 1'b0;
      end
      t = nxt;
    end
    r_len = t + 1;
  endtask

  // Called at posedge+2: this interval is offset 0, arbitration at its end.
  task automatic run_round(input bit ireq, input logic [31:0] iaddr, input int ilat,
                           input logic [31:0] idata, input bit dreq, input logic [31:0] daddr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int dlat, input logic [31:0] ddata);
    model_round(ireq, iaddr, ilat, idata, dreq, daddr, wdata, wstrb, dlat, ddata);
    s_ilat = ilat; s_idata = idata; s_dlat = dlat; s_ddata = ddata;
    imem_valid = ireq; imem_addr = iaddr;
    dmem_valid = dreq; dmem_addr = daddr; dmem_wdata = wdata; dmem_wstrb = wstrb;
    cyc = 0; chk_on = 1'b1;
    repeat (r_len) begin
      @(posedge clock); #2;
      if (imem_ready) imem_valid = 1'b0;
      if (dmem_ready) dmem_valid = 1'b0;
    end
    imem_valid = 1'b0; dmem_valid = 1'b0;
  endtask

  // Slave responder plus noise on every unselected ready/rdata lane.
  always @(negedge clock) begin
    int lat;
    logic [31:0] dat;
    logic [6:0] rdy;
    logic [6:0][31:0] rd;
    lat = bus_instr ? s_ilat : s_dlat;
    dat = bus_instr ? s_idata : s_ddata;
    if (bus_valid != '0) begin
      rdy = (scnt == lat) ? bus_valid : 7'b0;
      scnt++;
    end else begin
      rdy = '0;
      scnt = 0;
    end
    bus_ready = rdy | (7'($urandom) & ~bus_valid);
    for (int i = 0; i < 7; i++) rd[i] = bus_valid[i] ? dat : $urandom;
    bus_rdata = rd;
  end

  // Compare process.
  always @(negedge clock) begin
    if (chk_on) begin
      if (cyc < NSLOT) begin
        a_valid[cyc] = bus_valid; a_instr[cyc] = bus_instr; a_addr[cyc] = bus_addr;
        a_wdata[cyc] = bus_wdata; a_wstrb[cyc] = bus_wstrb;
        a_irdy[cyc] = imem_ready; a_ierr[cyc] = imem_error; a_irdat[cyc] = imem_rdata;
        a_drdy[cyc] = dmem_ready; a_derr[cyc] = dmem_error; a_drdat[cyc] = dmem_rdata;
        chk("bus_valid",  cyc, 32'(bus_valid),  32'(e_valid[cyc]));
        chk("bus_instr",  cyc, 32'(bus_instr),  32'(e_instr[cyc]));
        chk("bus_addr",   cyc, bus_addr,        e_addr[cyc]);
        chk("bus_wdata",  cyc, bus_wdata,       e_wdata[cyc]);
        chk("bus_wstrb",  cyc, 32'(bus_wstrb),  32'(e_wstrb[cyc]));
        chk("imem_ready", cyc, 32'(imem_ready), 32'(e_irdy[cyc]));
        chk("imem_error", cyc, 32'(imem_error), 32'(e_ierr[cyc]));
        chk("imem_rdata", cyc, imem_rdata,      e_irdat[cyc]);
        chk("dmem_ready", cyc, 32'(dmem_ready), 32'(e_drdy[cyc]));
        chk("dmem_error", cyc, 32'(dmem_error), 32'(e_derr[cyc]));
        chk("dmem_rdata", cyc, dmem_rdata,      e_drdat[cyc]);
      end
      cyc++;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_valid"}, 0, 32'(bus_valid), 32'h0);
    chk({tag, "_bus_instr"}, 0, 32'(bus_instr), 32'h0);
    chk({tag, "_bus_addr"},  0, bus_addr, 32'h0);
    chk({tag, "_bus_wstrb"}, 0, 32'(bus_wstrb), 32'h0);
    chk({tag, "_imem_ready"}, 0, 32'(imem_ready), 32'h0);
    chk({tag, "_dmem_ready"}, 0, 32'(dmem_ready), 32'h0);
    chk({tag, "_imem_rdata"}, 0, imem_rdata, 32'h0);
  endtask

  int lat_tab [8] = '{0, 0, 1, 2, 3, 7, 8, 100};
  logic [31:0] unmapped_tab [5] = '{32'h3000_0000, 32'h0020_0000, 32'h0100_0200,
                                   32'h9000_0000, 32'h0201_0000};

  function automatic logic [31:0] pick_addr();
    int r, k;
    r = $urandom_range(0, 9);
    if (r >= 7) return unmapped_tab[$urandom_range(0, 4)];
    k = $urandom_range(0, 2);
    if (k == 0) return t_lo[r];
    if (k == 1) return t_lo[r] + t_sz[r] - 32'd1;
    return t_lo[r] + ($urandom % t_sz[r]);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit any;
    #1 reset = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    model_reset();
    @(posedge clock); #2;

    // Both pending right after reset: data (UART TX) first, then fetch (ROM).
    run_round(1'b1, 32'h0000_0000, 0, 32'h1111_2222, 1'b1, 32'h0100_0000, 32'h0, 4'h0, 0, 32'h3333_4444);
    chk("both_first_valid", 1, 32'(a_valid[1]), 32'h04);
    chk("both_first_instr", 1, 32'(a_instr[1]), 32'h0);
    chk("both_first_dready", 2, 32'(a_drdy[2]), 32'h1);
    chk("both_second_valid", 4, 32'(a_valid[4]), 32'h01);
    chk("both_second_iready", 5, 32'(a_irdy[5]), 32'h1);

    // Fetch from ROM with two wait cycles.
    run_round(1'b1, 32'h0000_0010, 2, 32'h0000_0013, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    chk("fetch_valid", 1, 32'(a_valid[1]), 32'h01);
    chk("fetch_instr", 1, 32'(a_instr[1]), 32'h1);
    chk("fetch_valid_last", 3, 32'(a_valid[3]), 32'h01);
    chk("fetch_valid_drop", 4, 32'(a_valid[4]), 32'h00);
    chk("fetch_iready", 4, 32'(a_irdy[4]), 32'h1);
    chk("fetch_irdata", 4, a_irdat[4], 32'h0000_0013);
    chk("fetch_ierror", 4, 32'(a_ierr[4]), 32'h0);

    // Data write to SRAM.
    run_round(1'b0, 32'h0, 0, 32'h0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
    chk("wr_valid", 1, 32'(a_valid[1]), 32'h40);
    chk("wr_addr", 1, a_addr[1], 32'h8000_0004);
    chk("wr_wdata", 1, a_wdata[1], 32'hDEAD_BEEF);
    chk("wr_wstrb", 1, 32'(a_wstrb[1]), 32'hF);
    chk("wr_dready", 2, 32'(a_drdy[2]), 32'h1);
    chk("wr_derror", 2, 32'(a_derr[2]), 32'h0);
    any = 1'b0;
    for (int k = 0; k < r_len; k++) any |= a_irdy[k];
    chk("wr_no_iready", 0, 32'(any), 32'h0);

    // Unmapped data read.
    run_round(1'b0, 32'h0, 0, 32'h0, 1'b1, 32'h3000_0000, 32'h0, 4'h0, 0, 32'h5555_5555);
    chk("unmap_valid", 1, 32'(a_valid[1]), 32'h0);
    chk("unmap_dready", 1, 32'(a_drdy[1]), 32'h1);
    chk("unmap_derror", 1, 32'(a_derr[1]), 32'h1);
    chk("unmap_drdata", 1, a_drdat[1], 32'h0);

    // SPI read with a slave that never answers.
    run_round(1'b0, 32'h0, 0, 32'h0, 1'b1, 32'h0010_0000, 32'h0, 4'h0, 100, 32'h7777_7777);
    cnt = 0;
    for (int k = 0; k < r_len; k++) if (a_valid[k][1]) cnt++;
    chk("tmo_valid_cycles", 0, 32'(cnt), 32'd8);
    chk("tmo_dready", 9, 32'(a_drdy[9]), 32'h1);
    chk("tmo_derror", 9, 32'(a_derr[9]), 32'h1);

    // Reset in the middle of a request.
    chk_on = 1'b0;
    s_ilat = 100; imem_addr = 32'h0000_0010; imem_valid = 1'b1;
    @(posedge clock); @(posedge clock); #2;
    chk("midreset_pre_valid", 0, 32'(bus_valid), 32'h01);
    #3 reset = 1'b0;
    #1 chk_all_zero("midreset");
    imem_valid = 1'b0;
    @(posedge clock); #2 reset = 1'b1;
    model_reset();
    @(posedge clock); #2;
    run_round(1'b1, 32'h0000_0100, 1, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    chk("postreset_iready", 3, 32'(a_irdy[3]), 32'h1);
    chk("postreset_irdata", 3, a_irdat[3], 32'hCAFE_F00D);

    // Randomized rounds.
    for (int r = 0; r < 250; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0], pick_addr(), lat_tab[$urandom_range(0, 7)], $urandom,
                sel[1], pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                lat_tab[$urandom_range(0, 7)], $urandom);
    end
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
